mem_io_responder: RTL and testbench

- Target-side end of the CPU byte bus (address, write strobe, data out, data in, ready). It answers every CPU access: 128 KB byte RAM plus the memory-mapped I/O page at mem_a[17:16]==2'b11.
- I/O page provides a byte output stream (TX FIFO), a byte input stream (RX FIFO), a 32-bit cycle counter, and a program-stop flag.
- Drives the CPU ready input. It back-pressures the CPU when TX is nearly full, and freezes the CPU after program stop.

---
 rtl/mem_io_responder_pkg.sv | 16 +
 rtl/mem_io_responder_if.sv | 30 +++
 rtl/mem_io_responder_byte_fifo.sv | 66 ++++++
 rtl/mem_io_responder.sv | 172 +++++++++++++++++
 tb/tb_mem_io_responder.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_io_responder_pkg.sv
// Shared definitions for the CPU-side memory/IO responder.
// Holds the I/O page decode constants, the byte and counter widths,
// and the byte type that the interface, FIFO and top module all use.
package mem_io_responder_pkg;

    localparam int BYTE_W    = 8;
    localparam int CNT_W     = 32;
    localparam int IO_ADDR_W = 18;

    localparam logic [IO_ADDR_W-1:0] IO_BASE = 18'h30000;
    localparam logic [IO_ADDR_W-1:0] IO_CLK  = 18'h30004;
    localparam logic [1:0]           IO_PAGE = 2'b11;

    typedef logic [BYTE_W-1:0] byte_t;

endpackage

// File: rtl/mem_io_responder_if.sv
// CPU byte bus plus the TX/RX byte streams and the stop flag.
//   slave  : the responder (drives bus_dout, rdy_out, tx_*, rx_ready, program_stop)
//   master : the CPU / stream environment
interface mem_io_responder_if;
    import mem_io_responder_pkg::*;

    logic [31:0] bus_a;
    logic        bus_wr;
    byte_t       bus_din;
    byte_t       bus_dout;
    logic        rdy_out;
    byte_t       tx_data;
    logic        tx_valid;
    logic        tx_ready;
    byte_t       rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        program_stop;

    modport slave (
        input  bus_a, bus_wr, bus_din, tx_ready, rx_data, rx_valid,
        output bus_dout, rdy_out, tx_data, tx_valid, rx_ready, program_stop
    );

    modport master (
        output bus_a, bus_wr, bus_din, tx_ready, rx_data, rx_valid,
        input  bus_dout, rdy_out, tx_data, tx_valid, rx_ready, program_stop
    );

endinterface

// File: rtl/mem_io_responder_byte_fifo.sv
// byte_fifo: small synchronous byte FIFO with show-ahead head output.
// Ports:
//   clk_in, rst_in : clock, asynchronous active-high reset (empties the FIFO)
//   push/push_data : write one byte (dropped when full unless a pop frees a slot)
//   pop            : remove the head byte (ignored when empty)
//   head           : current head byte (meaningful only when !empty)
//   count          : number of stored bytes, 0..DEPTH
//   empty/full     : count == 0 / count == DEPTH
module byte_fifo
    import mem_io_responder_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   push,
    input  byte_t                  push_data,
    input  logic                   pop,
    output byte_t                  head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);
    localparam int              PW       = $clog2(DEPTH);
    localparam logic [PW:0]     FULL_CNT = (PW+1)'(DEPTH);

    byte_t         mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [PW:0]   count_q;
    logic          push_en;
    logic          pop_en;

    assign empty   = (count_q == '0);
    assign full    = (count_q == FULL_CNT);
    assign pop_en  = pop & ~empty;
    // A simultaneous pop frees the slot the push needs.
    assign push_en = push & (~full | pop_en);
    assign head    = mem_q[rd_ptr_q];
    assign count   = count_q;

    // Storage is not reset: reset empties the FIFO through the pointers.
    always_ff @(posedge clk_in) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_en)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_en, pop_en})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/mem_io_responder.sv
// mem_io_responder: target end of the CPU byte bus.
// Answers every accepted access with a 2^RAM_ADDR_WIDTH byte RAM, or with the
// I/O page (bus_a[17:16]==2'b11): TX stream, RX stream, free-running cycle
// counter with snapshot, and a sticky program-stop flag.
// Ports:
//   clk_in, rst_in : clock, asynchronous active-high reset
//   bus            : slave side of mem_io_responder_if (CPU bus, TX/RX streams,
//                    rdy_out back-pressure, program_stop)
module mem_io_responder
    import mem_io_responder_pkg::*;
#(
    parameter int RAM_ADDR_WIDTH = 17,
    parameter int TX_DEPTH       = 16,
    parameter int RX_DEPTH       = 4
) (
    input  logic              clk_in,
    input  logic              rst_in,
    mem_io_responder_if.slave bus
);
    localparam int               TX_CW       = $clog2(TX_DEPTH) + 1;
    localparam int               RX_CW       = $clog2(RX_DEPTH) + 1;
    localparam logic [TX_CW-1:0] TX_RDY_MAX  = TX_CW'(TX_DEPTH - 2);
    localparam logic [RX_CW-1:0] RX_FULL_CNT = RX_CW'(RX_DEPTH);

    logic [IO_ADDR_W-1:0] addr;
    logic                 unused_addr_hi;
    logic                 io_sel, ram_wr, ram_rd;

    logic                 rdy_q, rdy_d;
    logic                 rx_ready_q, rx_ready_d;
    logic                 stop_q, stop_d;
    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     snap_q, snap_d;
    byte_t                io_rd_q, io_rd_d;
    logic                 io_rd;
    logic                 src_ram_q;
    byte_t                ram_rd_q;
    byte_t                ram_mem [2**RAM_ADDR_WIDTH];

    logic                 tx_push, tx_pop, tx_empty, unused_tx_full;
    byte_t                tx_push_data, tx_head;
    logic [TX_CW-1:0]     tx_count, tx_count_d;
    logic                 rx_push, rx_pop, rx_pop_eff, rx_empty, unused_rx_full;
    byte_t                rx_head;
    logic [RX_CW-1:0]     rx_count, rx_count_d;

    assign addr           = bus.bus_a[IO_ADDR_W-1:0];
    assign unused_addr_hi = ^bus.bus_a[31:IO_ADDR_W];
    assign io_sel         = (addr[IO_ADDR_W-1:IO_ADDR_W-2] == IO_PAGE);
    // Only cycles with rdy_out high are real accesses.
    assign ram_wr         = rdy_q &  bus.bus_wr & ~io_sel;
    assign ram_rd         = rdy_q & ~bus.bus_wr & ~io_sel;

    assign tx_pop         = ~tx_empty & bus.tx_ready;
    assign rx_push        = bus.rx_valid & rx_ready_q;
    assign rx_pop_eff     = rx_pop & ~rx_empty;

    // I/O page decode.
    always_comb begin
        tx_push      = 1'b0;
        tx_push_data = '0;
        rx_pop       = 1'b0;
        io_rd        = 1'b0;
        io_rd_d      = '0;
        snap_d       = snap_q;
        stop_d       = stop_q;
        if (rdy_q && io_sel) begin
            if (bus.bus_wr) begin
                if (addr == IO_BASE && bus.bus_din != '0) begin
                    tx_push      = 1'b1;
                    tx_push_data = bus.bus_din;
                end else if (addr == IO_CLK) begin
                    // Stop marker: a zero byte goes out regardless of the zero filter.
                    tx_push = 1'b1;
                    stop_d  = 1'b1;
                end
            end else begin
                io_rd = 1'b1;
                case (addr)
                    IO_BASE: begin
                        rx_pop  = 1'b1;
                        io_rd_d = rx_empty ? '0 : rx_head;
                    end
                    IO_CLK: begin
                        io_rd_d = cnt_q[7:0];
                        snap_d  = cnt_q;
                    end
                    IO_CLK + 18'd1: io_rd_d = snap_q[15:8];
                    IO_CLK + 18'd2: io_rd_d = snap_q[23:16];
                    IO_CLK + 18'd3: io_rd_d = snap_q[31:24];
                    default:        io_rd_d = '0;
                endcase
            end
        end
    end

    // Next FIFO occupancies feed the registered ready flags, so a push taken
    // while rdy_out is high always has a free TX slot.
    always_comb begin
        tx_count_d = tx_count;
        if (tx_push && !tx_pop)      tx_count_d = tx_count + 1'b1;
        else if (!tx_push && tx_pop) tx_count_d = tx_count - 1'b1;
        rx_count_d = rx_count;
        if (rx_push && !rx_pop_eff)      rx_count_d = rx_count + 1'b1;
        else if (!rx_push && rx_pop_eff) rx_count_d = rx_count - 1'b1;
        rdy_d      = ~stop_d & (tx_count_d <= TX_RDY_MAX);
        rx_ready_d = (rx_count_d < RX_FULL_CNT);
    end

    // Byte RAM with registered read; contents survive reset.
    always_ff @(posedge clk_in) begin
        if (ram_wr) ram_mem[addr[RAM_ADDR_WIDTH-1:0]] <= bus.bus_din;
        if (ram_rd) ram_rd_q <= ram_mem[addr[RAM_ADDR_WIDTH-1:0]];
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rdy_q      <= 1'b0;
            rx_ready_q <= 1'b0;
            stop_q     <= 1'b0;
            cnt_q      <= '0;
            snap_q     <= '0;
            io_rd_q    <= '0;
            src_ram_q  <= 1'b0;
        end else begin
            rdy_q      <= rdy_d;
            rx_ready_q <= rx_ready_d;
            stop_q     <= stop_d;
            cnt_q      <= cnt_q + 1'b1;
            snap_q     <= snap_d;
            // bus_dout source tracks the last accepted read.
            if (io_rd) begin
                io_rd_q   <= io_rd_d;
                src_ram_q <= 1'b0;
            end else if (ram_rd) begin
                src_ram_q <= 1'b1;
            end
        end
    end

    byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .push      (tx_push),
        .push_data (tx_push_data),
        .pop       (tx_pop),
        .head      (tx_head),
        .count     (tx_count),
        .empty     (tx_empty),
        .full      (unused_tx_full)
    );

    byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .push      (rx_push),
        .push_data (bus.rx_data),
        .pop       (rx_pop),
        .head      (rx_head),
        .count     (rx_count),
        .empty     (rx_empty),
        .full      (unused_rx_full)
    );

    assign bus.bus_dout     = src_ram_q ? ram_rd_q : io_rd_q;
    assign bus.rdy_out      = rdy_q;
    assign bus.tx_data      = tx_head;
    assign bus.tx_valid     = ~tx_empty;
    assign bus.rx_ready     = rx_ready_q;
    assign bus.program_stop = stop_q;

endmodule

// File: tb/tb_mem_io_responder.sv
module tb_mem_io_responder;
    localparam int TXD = 4;
    localparam int RXD = 4;

    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    always #5 clk_in = ~clk_in;

    mem_io_responder_if bus_if ();

    mem_io_responder #(.RAM_ADDR_WIDTH(17), .TX_DEPTH(TXD), .RX_DEPTH(RXD)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus_if)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: byte RAM as a sparse map, streams as queues.
    logic [7:0]  m_ram [int];
    logic [7:0]  m_txq [$];
    logic [7:0]  m_rxq [$];
    logic [7:0]  dut_tx [$];
    logic [31:0] m_cnt, m_snap;
    logic        m_rdy, m_rxr, m_stop;
    logic [7:0]  m_dout;
    bit          m_dout_known;

    logic        g_txr = 1'b0, g_rxv = 1'b0;
    logic [7:0]  g_rxd = 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_txq.delete();
        m_rxq.delete();
        m_cnt = 0; m_snap = 0;
        m_rdy = 0; m_rxr = 0; m_stop = 0;
        m_dout = 0; m_dout_known = 1;
    endtask

    // One clock: drive the bus, advance the model across the edge, check outputs.
    task automatic bus_op(input logic wr, input logic [31:0] a, input logic [7:0] d,
                          output logic accepted);
        logic [17:0] ad;
        bus_if.bus_wr   = wr;
        bus_if.bus_a    = a;
        bus_if.bus_din  = d;
        bus_if.tx_ready = g_txr;
        bus_if.rx_valid = g_rxv;
        bus_if.rx_data  = g_rxd;
        accepted = m_rdy;
        if (bus_if.tx_valid && g_txr) dut_tx.push_back(bus_if.tx_data);
        @(posedge clk_in);
        ad = a[17:0];
        if (g_txr && m_txq.size() != 0) void'(m_txq.pop_front());
        if (m_rdy) begin
            if (ad[17:16] != 2'b11) begin
                if (wr) m_ram[int'(ad[16:0])] = d;
                else if (m_ram.exists(int'(ad[16:0]))) begin
                    m_dout = m_ram[int'(ad[16:0])]; m_dout_known = 1;
                end else m_dout_known = 0;
            end else if (wr) begin
                if (ad == 18'h30000 && d != 0) m_txq.push_back(d);
                else if (ad == 18'h30004) begin m_txq.push_back(8'h00); m_stop = 1; end
            end else begin
                m_dout_known = 1;
                case (ad)
                    18'h30000: begin
                        m_dout = 8'h00;
                        if (m_rxq.size() != 0) m_dout = m_rxq.pop_front();
                    end
                    18'h30004: begin m_dout = m_cnt[7:0]; m_snap = m_cnt; end
                    18'h30005: m_dout = m_snap[15:8];
                    18'h30006: m_dout = m_snap[23:16];
                    18'h30007: m_dout = m_snap[31:24];
                    default:   m_dout = 8'h00;
                endcase
            end
        end
        if (g_rxv && m_rxr) m_rxq.push_back(g_rxd);
        m_cnt++;
        m_rdy = !m_stop && (m_txq.size() <= TXD - 2);
        m_rxr = (m_rxq.size() < RXD);
        #1;
        chk("rdy_out", bus_if.rdy_out, m_rdy);
        chk("program_stop", bus_if.program_stop, m_stop);
        chk("tx_valid", bus_if.tx_valid, m_txq.size() != 0);
        if (m_txq.size() != 0) chk("tx_data", bus_if.tx_data, m_txq[0]);
        chk("rx_ready", bus_if.rx_ready, m_rxr);
        if (m_dout_known) chk("bus_dout", bus_if.bus_dout, m_dout);
    endtask

    // Harmless cycle: write to an unused I/O address.
    task automatic idle();
        logic acc;
        bus_op(1'b1, 32'h0003FFF0, 8'h00, acc);
    endtask

    task automatic cpu_access(input logic wr, input logic [31:0] a, input logic [7:0] d);
        logic acc;
        int   tries;
        acc = 0; tries = 0;
        while (!acc && tries < 20) begin
            bus_op(wr, a, d, acc);
            tries++;
        end
        chk("access_accepted", {31'b0, acc}, 32'd1);
    endtask

    // Assert reset mid-cycle, check outputs clear at once, hold over one edge.
    task automatic do_reset();
        #2 rst_in = 1'b1;
        #1;
        chk("rst_bus_dout", bus_if.bus_dout, 0);
        chk("rst_rdy_out", bus_if.rdy_out, 0);
        chk("rst_tx_valid", bus_if.tx_valid, 0);
        chk("rst_rx_ready", bus_if.rx_ready, 0);
        chk("rst_program_stop", bus_if.program_stop, 0);
        model_reset();
        @(posedge clk_in);
        #3 rst_in = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        acc;
        int          n;
        logic [31:0] asm;
        bus_if.bus_a = 0; bus_if.bus_wr = 0; bus_if.bus_din = 0;
        bus_if.tx_ready = 0; bus_if.rx_valid = 0; bus_if.rx_data = 0;
        model_reset();
        @(posedge clk_in); #1;
        do_reset();

        // First edge after release raises rdy_out and rx_ready.
        idle();

        // RAM write/read, read-after-write, hold, upper address bits ignored.
        cpu_access(1'b1, 32'h00000123, 8'hA5);
        cpu_access(1'b0, 32'h00000123, 8'h00);
        chk("ram_read_a5", bus_if.bus_dout, 8'hA5);
        cpu_access(1'b0, 32'h00000124, 8'h00);
        cpu_access(1'b1, 32'h00000200, 8'h5A);
        cpu_access(1'b0, 32'h00000200, 8'h00);
        chk("ram_raw", bus_if.bus_dout, 8'h5A);
        idle();
        chk("dout_hold", bus_if.bus_dout, 8'h5A);
        cpu_access(1'b0, 32'hFFFC0123, 8'h00);
        chk("ram_hi_bits", bus_if.bus_dout, 8'hA5);

        // TX stream drops zero bytes written to 0x30000.
        g_txr = 1'b1; dut_tx.delete();
        cpu_access(1'b1, 32'h00030000, 8'h48);
        cpu_access(1'b1, 32'h00030000, 8'h00);
        cpu_access(1'b1, 32'h00030000, 8'h69);
        repeat (4) idle();
        chk("tx_stream_len", dut_tx.size(), 2);
        if (dut_tx.size() == 2) begin
            chk("tx_stream_0", dut_tx[0], 8'h48);
            chk("tx_stream_1", dut_tx[1], 8'h69);
        end

        // TX back-pressure with depth 4: only 3 bytes fit.
        g_txr = 1'b0; dut_tx.delete(); n = 0;
        for (int i = 0; i < 6; i++) begin
            bus_op(1'b1, 32'h00030000, 8'(8'h41 + n), acc);
            if (acc) n++;
        end
        chk("tx_accepted_until_full", n, 3);
        g_txr = 1'b1;
        bus_op(1'b1, 32'h00030000, 8'(8'h41 + n), acc);
        chk("pulse_write_blocked", {31'b0, acc}, 0);
        chk("rdy_after_pulse", bus_if.rdy_out, 1);
        g_txr = 1'b0;
        bus_op(1'b1, 32'h00030000, 8'(8'h41 + n), acc);
        chk("fourth_write_taken", {31'b0, acc}, 1);
        bus_op(1'b1, 32'h00030000, 8'h45, acc);
        chk("fifth_write_blocked", {31'b0, acc}, 0);
        g_txr = 1'b1;
        repeat (5) idle();
        chk("tx_drain_len", dut_tx.size(), 4);
        for (int i = 0; i < 4 && i < dut_tx.size(); i++)
            chk("tx_drain_order", dut_tx[i], 32'(8'h41 + i));

        // RX stream, empty read, and full/ready boundary.
        g_txr = 1'b0;
        g_rxv = 1'b1; g_rxd = 8'h31; idle();
        g_rxd = 8'h32; idle();
        g_rxv = 1'b0;
        cpu_access(1'b0, 32'h00030000, 8'h00); chk("rx_read_0", bus_if.bus_dout, 8'h31);
        cpu_access(1'b0, 32'h00030000, 8'h00); chk("rx_read_1", bus_if.bus_dout, 8'h32);
        cpu_access(1'b0, 32'h00030000, 8'h00); chk("rx_read_empty", bus_if.bus_dout, 8'h00);
        g_rxv = 1'b1;
        for (int i = 0; i < 5; i++) begin
            g_rxd = 8'(8'h50 + i);
            idle();
        end
        g_rxv = 1'b0;
        chk("rx_full_not_ready", bus_if.rx_ready, 0);
        cpu_access(1'b0, 32'h00030000, 8'h00);
        chk("rx_ready_after_pop", bus_if.rx_ready, 1);
        chk("rx_full_read", bus_if.bus_dout, 8'h50);
        for (int i = 1; i < 4; i++) begin
            cpu_access(1'b0, 32'h00030000, 8'h00);
            chk("rx_full_order", bus_if.bus_dout, 32'(8'h50 + i));
        end

        // Counter snapshot, assembled little-endian.
        while (m_cnt < 100) idle();
        cpu_access(1'b0, 32'h00030004, 8'h00); asm[7:0]   = bus_if.bus_dout;
        idle();
        cpu_access(1'b0, 32'h00030005, 8'h00); asm[15:8]  = bus_if.bus_dout;
        idle();
        cpu_access(1'b0, 32'h00030006, 8'h00); asm[23:16] = bus_if.bus_dout;
        cpu_access(1'b0, 32'h00030007, 8'h00); asm[31:24] = bus_if.bus_dout;
        chk("snapshot", asm, m_snap);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] ra;
            logic        rw;
            logic [7:0]  rdat;
            g_txr = 1'($urandom_range(0, 1));
            g_rxv = ($urandom_range(0, 3) == 0);
            g_rxd = 8'($urandom);
            rdat  = 8'($urandom);
            case ($urandom_range(0, 5))
                0: begin rw = 1'b1; ra = 32'h300 + 32'($urandom_range(0, 15)); end
                1: begin rw = 1'b0; ra = 32'h300 + 32'($urandom_range(0, 15)); end
                2: begin rw = 1'b1; ra = 32'h30000; if ($urandom_range(0, 3) == 0) rdat = 8'h00; end
                3: begin rw = 1'b0; ra = 32'h30000; end
                4: begin rw = 1'b0; ra = 32'h30004 + 32'($urandom_range(0, 3)); end
                default: begin rw = 1'($urandom_range(0, 1)); ra = 32'h30008 + 32'($urandom_range(0, 200)); end
            endcase
            ra = ra | ($urandom & 32'hFFFC0000);
            bus_op(rw, ra, rdat, acc);
        end
        g_txr = 1'b1; g_rxv = 1'b0;
        for (int i = 0; i < 20 && m_txq.size() != 0; i++) idle();
        chk("tx_drained", bus_if.tx_valid, 0);

        // Program stop: zero marker emitted, bus frozen, TX still drains.
        g_txr = 1'b0; dut_tx.delete();
        cpu_access(1'b1, 32'h00030000, 8'h77);
        cpu_access(1'b1, 32'h00030004, 8'h5C);
        chk("stop_flag", bus_if.program_stop, 1);
        chk("stop_rdy_low", bus_if.rdy_out, 0);
        g_txr = 1'b1;
        bus_op(1'b1, 32'h00000123, 8'h11, acc);
        chk("stopped_write_blocked", {31'b0, acc}, 0);
        repeat (2) idle();
        chk("stop_tx_len", dut_tx.size(), 2);
        if (dut_tx.size() == 2) begin
            chk("stop_tx_0", dut_tx[0], 8'h77);
            chk("stop_tx_1", dut_tx[1], 8'h00);
        end
        do_reset();

        // Asynchronous reset mid-drain discards queued TX bytes.
        g_txr = 1'b0;
        cpu_access(1'b1, 32'h00030000, 8'h61);
        cpu_access(1'b1, 32'h00030000, 8'h62);
        cpu_access(1'b1, 32'h00030000, 8'h63);
        g_txr = 1'b1;
        idle();
        do_reset();
        idle();
        cpu_access(1'b0, 32'h00000123, 8'h00);
        chk("ram_kept_over_reset", bus_if.bus_dout, 8'hA5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
